// File: rtl/hazard_fwd_scoreboard.sv
// Hazard detection and EXE forwarding control for the 5-stage core.
// A two-entry scoreboard tracks the writers now in EXE (E0) and MEM (E1).
module hazard_fwd_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic                  id_src1_en,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_r,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            exe_fwd_sel1,
  output logic [1:0]            exe_fwd_sel2,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                  e0_vld_q, e0_vld_d, e0_ld_q, e0_ld_d;
  logic [REG_ADDR_W-1:0] e0_dest_q, e0_dest_d;
  logic                  e1_vld_q, e1_ld_q;
  logic [REG_ADDR_W-1:0] e1_dest_q;
  logic [1:0]            sel1_q, sel1_d, sel2_q, sel2_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic m1_e0, m2_e0, m1_e1, m2_e1;
  logic live, hazard, issue;

  assign m1_e0 = id_src1_en & e0_vld_q & (e0_dest_q == id_src1);
  assign m2_e0 = id_two_src & e0_vld_q & (e0_dest_q == id_src2);
  assign m1_e1 = id_src1_en & e1_vld_q & (e1_dest_q == id_src1);
  assign m2_e1 = id_two_src & e1_vld_q & (e1_dest_q == id_src2);

  // Flush kills the ID instruction, so it can never be the one stalled.
  assign live   = id_valid & ~flush;
  assign hazard = FWD_EN ? ((m1_e0 | m2_e0) & e0_ld_q)
                         : (m1_e0 | m2_e0 | m1_e1 | m2_e1);
  assign stall  = live & hazard;
  assign issue  = live & ~hazard;

  always_comb begin
    sel1_d = SEL_RF;
    sel2_d = SEL_RF;
    if (FWD_EN && issue) begin
      if (m1_e0 && !e0_ld_q) sel1_d = SEL_MEM;
      else if (m1_e1)        sel1_d = SEL_WB;
      if (m2_e0 && !e0_ld_q) sel2_d = SEL_MEM;
      else if (m2_e1)        sel2_d = SEL_WB;
    end
  end

  always_comb begin
    e0_vld_d  = 1'b0;
    e0_dest_d = id_dest;
    e0_ld_d   = 1'b0;
    if (issue) begin
      e0_vld_d = id_wb_en;
      e0_ld_d  = id_mem_r;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_vld_q    <= 1'b0;
      e0_dest_q   <= '0;
      e0_ld_q     <= 1'b0;
      e1_vld_q    <= 1'b0;
      e1_dest_q   <= '0;
      e1_ld_q     <= 1'b0;
      sel1_q      <= SEL_RF;
      sel2_q      <= SEL_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e1_vld_q    <= e0_vld_q;
      e1_dest_q   <= e0_dest_q;
      e1_ld_q     <= e0_ld_q;
      e0_vld_q    <= e0_vld_d;
      e0_dest_q   <= e0_dest_d;
      e0_ld_q     <= e0_ld_d;
      sel1_q      <= sel1_d;
      sel2_q      <= sel2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign exe_fwd_sel1 = sel1_q;
  assign exe_fwd_sel2 = sel2_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Self-checking bench: three configurations share one ID stream and are
// compared every cycle against an issue-history model, plus directed cases.
module tb_hazard_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_src1_en = 1'b0, id_two_src = 1'b0;
  logic       id_wb_en = 1'b0, id_mem_r = 1'b0, flush = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;

  logic       st0, st1, st2;
  logic [1:0] a1_0, a1_1, a1_2, a2_0, a2_1, a2_2;
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [1:0]  sc2, fc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_fwd_scoreboard #(.REG_ADDR_W(4), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r(id_mem_r), .flush(flush), .stall(st0), .exe_fwd_sel1(a1_0),
    .exe_fwd_sel2(a2_0), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_fwd_scoreboard #(.REG_ADDR_W(4), .FWD_EN(1'b0), .CNT_W(16)) u_stl (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r(id_mem_r), .flush(flush), .stall(st1), .exe_fwd_sel1(a1_1),
    .exe_fwd_sel2(a2_1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_fwd_scoreboard #(.REG_ADDR_W(4), .FWD_EN(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r(id_mem_r), .flush(flush), .stall(st2), .exe_fwd_sel1(a1_2),
    .exe_fwd_sel2(a2_2), .stall_cnt(sc2), .flush_cnt(fc2));

  // ---------------- DUT output access ----------------
  function automatic logic [31:0] d_stall(int k);
    return (k == 0) ? {31'b0, st0} : (k == 1) ? {31'b0, st1} : {31'b0, st2};
  endfunction
  function automatic logic [31:0] d_sel1(int k);
    return (k == 0) ? {30'b0, a1_0} : (k == 1) ? {30'b0, a1_1} : {30'b0, a1_2};
  endfunction
  function automatic logic [31:0] d_sel2(int k);
    return (k == 0) ? {30'b0, a2_0} : (k == 1) ? {30'b0, a2_1} : {30'b0, a2_2};
  endfunction
  function automatic logic [31:0] d_scnt(int k);
    return (k == 0) ? {16'b0, sc0} : (k == 1) ? {16'b0, sc1} : {30'b0, sc2};
  endfunction
  function automatic logic [31:0] d_fcnt(int k);
    return (k == 0) ? {16'b0, fc0} : (k == 1) ? {16'b0, fc1} : {30'b0, fc2};
  endfunction

  // ---------------- Reference model ----------------
  // hist1/hist2 hold the instruction issued one / two cycles ago (or none).
  typedef struct packed {
    bit       w;
    bit [3:0] d;
    bit       ld;
  } wr_t;

  int  fwd_m [3] = '{1, 0, 0};
  int  cmax  [3] = '{65535, 65535, 3};
  wr_t hist1 [3] = '{default: '0};
  wr_t hist2 [3] = '{default: '0};
  int  m_sel1[3] = '{default: 0};
  int  m_sel2[3] = '{default: 0};
  int  m_scnt[3] = '{default: 0};
  int  m_fcnt[3] = '{default: 0};

  function automatic bit reads(wr_t w, bit en, bit [3:0] s);
    return en && w.w && (w.d == s);
  endfunction

  function automatic bit m_stall(int k);
    bit dep1, dep2;
    if (!(id_valid && !flush)) return 1'b0;
    dep1 = reads(hist1[k], id_src1_en, id_src1) || reads(hist1[k], id_two_src, id_src2);
    dep2 = reads(hist2[k], id_src1_en, id_src1) || reads(hist2[k], id_two_src, id_src2);
    if (fwd_m[k] != 0) return dep1 && hist1[k].ld;
    return dep1 || dep2;
  endfunction

  function automatic bit m_issue(int k);
    return id_valid && !flush && !m_stall(k);
  endfunction

  function automatic int m_src_sel(int k, bit en, bit [3:0] s);
    if (fwd_m[k] == 0 || !m_issue(k)) return 0;
    if (reads(hist1[k], en, s) && !hist1[k].ld) return 1;
    if (reads(hist2[k], en, s)) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        hist1[k] <= '0;
        hist2[k] <= '0;
        m_sel1[k] <= 0;
        m_sel2[k] <= 0;
        m_scnt[k] <= 0;
        m_fcnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_sel1[k] <= m_src_sel(k, id_src1_en, id_src1);
        m_sel2[k] <= m_src_sel(k, id_two_src, id_src2);
        if (m_stall(k) && m_scnt[k] < cmax[k]) m_scnt[k] <= m_scnt[k] + 1;
        if (flush && m_fcnt[k] < cmax[k]) m_fcnt[k] <= m_fcnt[k] + 1;
        hist2[k] <= hist1[k];
        hist1[k] <= m_issue(k) ? wr_t'{id_wb_en, id_dest, id_mem_r} : wr_t'('0);
      end
    end
  end

  // ---------------- Checking ----------------
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("model_stall", k, d_stall(k), {31'b0, m_stall(k)});
      chk("model_sel1", k, d_sel1(k), m_sel1[k]);
      chk("model_sel2", k, d_sel2(k), m_sel2[k]);
      chk("model_stall_cnt", k, d_scnt(k), m_scnt[k]);
      chk("model_flush_cnt", k, d_fcnt(k), m_fcnt[k]);
    end
  end

  // ---------------- Stimulus ----------------
  task automatic drv(bit v, bit [3:0] s1, bit e1, bit [3:0] s2, bit t,
                     bit wb, bit [3:0] d, bit mr, bit fl);
    @(posedge clk);
    #1;
    id_valid = v;  id_src1 = s1; id_src1_en = e1; id_src2 = s2; id_two_src = t;
    id_wb_en = wb; id_dest = d;  id_mem_r = mr;   flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_valid = 0; id_src1_en = 0; id_two_src = 0; id_wb_en = 0; id_mem_r = 0; flush = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic bit [3:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};
  int si;
  bit [3:0] rs, rd;

  initial begin
    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      drv(1'($urandom), rreg(), 1'($urandom), rreg(), 1'($urandom),
          1'($urandom), rreg(), 1'($urandom), 1'($urandom));
      for (int k = 0; k < 2; k++) begin
        chk("rst_stall", k, d_stall(k), 0);
        chk("rst_sel1", k, d_sel1(k), 0);
        chk("rst_sel2", k, d_sel2(k), 0);
        chk("rst_scnt", k, d_scnt(k), 0);
        chk("rst_fcnt", k, d_fcnt(k), 0);
      end
    end
    idle();
    rst = 1'b1;
    idle();

    // ALU chain with forwarding
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drv(1, 1, 1, 0, 0, 1, 4, 0, 0);
    chk("alu_d1_stall", 0, d_stall(0), 0);
    idle();
    chk("alu_d1_sel1", 0, d_sel1(0), 1);
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
    drv(1, 1, 1, 0, 0, 1, 4, 0, 0);
    chk("alu_d2_stall", 0, d_stall(0), 0);
    idle();
    chk("alu_d2_sel1", 0, d_sel1(0), 2);

    // Load-use with forwarding
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0);
    drv(1, 0, 0, 3, 1, 1, 6, 0, 0);
    chk("lu_stall_first", 0, d_stall(0), 1);
    drv(1, 0, 0, 3, 1, 1, 6, 0, 0);
    chk("lu_stall_second", 0, d_stall(0), 0);
    idle();
    chk("lu_sel2", 0, d_sel2(0), 2);
    chk("lu_scnt", 0, d_scnt(0), 1);
    idle();
    idle();
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0);
    drv(1, 0, 0, 3, 0, 1, 6, 0, 0);
    chk("lu_nosrc2_stall", 0, d_stall(0), 0);
    idle();
    chk("lu_nosrc2_sel2", 0, d_sel2(0), 0);

    // Stall-only mode
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drv(1, 2, 1, 0, 0, 1, 7, 0, 0);
      chk("so_d1_stall", 1, d_stall(1), (c < 2) ? 1 : 0);
    end
    idle();
    chk("so_d1_scnt", 1, d_scnt(1), 2);
    chk("so_d1_sel1", 1, d_sel1(1), 0);
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 8, 0, 0);
    for (int c = 0; c < 2; c++) begin
      drv(1, 2, 1, 0, 0, 1, 7, 0, 0);
      chk("so_d2_stall", 1, d_stall(1), (c < 1) ? 1 : 0);
    end
    idle();
    chk("so_d2_scnt", 1, d_scnt(1), 3);

    // Flush overrides a load-use and leaves a bubble in E0
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0);
    drv(1, 0, 0, 3, 1, 1, 9, 1, 1);
    chk("fl_stall", 0, d_stall(0), 0);
    drv(1, 9, 1, 0, 0, 1, 10, 0, 0);
    chk("fl_bubble_stall", 0, d_stall(0), 0);
    chk("fl_fcnt", 0, d_fcnt(0), 1);

    // Counter saturation at CNT_W=2
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0);
    si = 0;
    for (int r = 0; r < 3; r++) begin
      rs = (r % 2 == 0) ? 4'd2 : 4'd3;
      rd = (r % 2 == 0) ? 4'd3 : 4'd2;
      drv(1, rs, 1, 0, 0, 1, rd, 0, 0);
      chk("sat_stall_a", 2, d_stall(2), 1);
      drv(1, rs, 1, 0, 0, 1, rd, 0, 0);
      chk("sat_cnt", 2, d_scnt(2), sat_exp[si]);
      si++;
      chk("sat_stall_b", 2, d_stall(2), 1);
      drv(1, rs, 1, 0, 0, 1, rd, 0, 0);
      chk("sat_cnt", 2, d_scnt(2), sat_exp[si]);
      si++;
      chk("sat_stall_c", 2, d_stall(2), 0);
    end

    // Randomised traffic, with occasional asynchronous resets
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      rst        = ($urandom_range(0, 49) != 0);
      id_valid   = ($urandom_range(0, 99) < 85);
      id_src1    = rreg();
      id_src1_en = 1'($urandom);
      id_src2    = rreg();
      id_two_src = 1'($urandom);
      id_wb_en   = ($urandom_range(0, 3) != 0);
      id_dest    = rreg();
      id_mem_r   = ($urandom_range(0, 2) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    rst = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_scoreboard.md
# hazard_fwd_scoreboard

Parametrised hazard-detection and forwarding-control block for the 5-stage core. It replaces the stall-only EXE/MEM destination compare with a registered scoreboard of in-flight writers in EXE and MEM. It runs in one of two modes:
- **Forwarding mode:** issues registered forwarding selects to EXE and stalls only on load-use.
- **Stall-only mode:** reproduces legacy stall behaviour.

It sits beside ID: it takes ID-stage decode fields and branch flush, and drives the PC/IF_ID freeze plus the EXE operand mux selects.

## Interface
Parameters:
- REG_ADDR_W, 4, register-address width.
- FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_ADDR_W  first source register (Rn).
- id_src1_en  in  1  src1 is read.
- id_src2  in  REG_ADDR_W  second source register (Rm/Rd-for-store).
- id_two_src  in  1  src2 is read.
- id_wb_en  in  1  ID instruction writes the register file.
- id_dest  in  REG_ADDR_W  ID destination register.
- id_mem_r  in  1  ID instruction is a load.
- flush  in  1  branch taken in EXE; the ID instruction is killed.
- stall  out  1  freeze PC and IF_ID; insert a bubble into ID_EX.
- exe_fwd_sel1  out  2  EXE operand-1 select: 00 regfile, 01 MEM ALU result, 10 WB value.
- exe_fwd_sel2  out  2  EXE operand-2 select, same encoding.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush=1, saturating.

## Operation
- **Scoreboard entries:** two entries, E0 (instruction now in EXE) and E1 (now in MEM). Each entry holds {vld, dest, ld}.
- **Shift each cycle:**
  - E1 <= E0.
  - E0 <= bubble (vld=0) if flush, stall or !id_valid.
  - Otherwise E0 <= {id_wb_en, id_dest, id_mem_r}.
- **Match:**
  - match(s, Ek) = Ek.vld & (Ek.dest == s).
  - A source s participates only when its enable is set: src1_en, or two_src for src2.
- **FWD_EN=1:**
  - stall = id_valid & !flush & (match(src1,E0) | match(src2,E0)) & E0.ld. This is the load-use case only.
  - Select for each source, registered into exe_fwd_selN:
    - 01 if match with E0 and !E0.ld.
    - else 10 if match with E1.
    - else 00.
  - E0 has priority over E1 (youngest writer wins).
- **FWD_EN=0:**
  - stall = id_valid & !flush & any participating source matches E0 or E1.
  - exe_fwd_sel1/2 are held at 00.
- **Bubbles:** when stall, flush or !id_valid, exe_fwd_sel1/2 <= 00.
- **Flush priority:** flush overrides stall. stall=0 in any cycle with flush=1.
- **Counters:**
  - stall_cnt increments in every cycle stall=1.
  - flush_cnt increments in every cycle flush=1.
  - Both saturate at all-ones with no wrap.
- **Register number:** no register number is special-cased; R15 compares like any other.

## Timing
- **Reset (rst=0, asynchronous):**
  - E0/E1 vld=0; exe_fwd_sel1/2=00; stall_cnt=0; flush_cnt=0.
  - stall therefore reads 0.
  - Deasserting rst mid-stall resumes with an empty scoreboard.
- **stall:** combinational, same cycle as the ID inputs. Its path is from registered E0/E1 plus ID inputs only, with no path from the counters.
- **exe_fwd_sel:** latency is one cycle. The select computed in ID cycle N is valid in cycle N+1, when that instruction occupies EXE.
- **Load-use (FWD_EN=1):** exactly one stall cycle. The next cycle the load is in E1, stall drops, and sel=10.
- **Stall-only mode (FWD_EN=0):**
  - Dependence at distance 1: two stall cycles.
  - Dependence at distance 2: one stall cycle.
  - Distance 3 or more: none; the regfile writes before it reads.
- **Simultaneous flush and stall condition:** stall=0, the bubble enters E0, and flush_cnt increments.
- **Dependence on both sources:** both sources may match different entries in the same cycle; each select resolves independently.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with random inputs -> stall=0, exe_fwd_sel1/2=00, stall_cnt=flush_cnt=0 throughout.
- **ALU chain, FWD_EN=1:** ADD R1 (wb_en=1, dest=1), then SUB with src1=1 -> stall=0; exe_fwd_sel1=01 in the SUB's EXE cycle. With one independent instruction between -> exe_fwd_sel1=10.
- **Load-use, FWD_EN=1:** LDR R3 (mem_r=1), then ADD with src2=3, two_src=1 -> stall=1 for exactly 1 cycle, then exe_fwd_sel2=10 and stall_cnt=1. Same pattern with two_src=0 -> stall=0, sel2=00.
- **Stall-only, FWD_EN=0:**
  - ADD R2, then a reader of R2 -> stall=1 for 2 cycles, stall_cnt=2.
  - Reader at distance 2 -> 1 cycle.
  - exe_fwd_sel stays 00.
- **Flush precedence:** load-use condition present with flush=1 in the same cycle -> stall=0, E0 bubble (the next dependent reader is not stalled), flush_cnt=1.
- **Saturation:** CNT_W=2, hold a stall-only dependence chain for 6 stall cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
